// File: rtl/bus_arbiter_2m_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_arbiter_2m_if : request/grant/response bus between a master  |
// | and a slave.  Rev 1.0                                            |
// +------------------------------------------------------------------+
interface bus_arbiter_2m_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req;
  logic            we;
  logic [DW/8-1:0] be;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;
  logic            err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter_2m.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_arbiter_2m : round-robin arbiter sharing one slave port      |
// | between two masters, with in-order response routing.  Rev 1.0    |
// +------------------------------------------------------------------+
module bus_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  bus_arbiter_2m_if.slave  m0,
  bus_arbiter_2m_if.slave  m1,
  bus_arbiter_2m_if.master s,
  output logic           spurious_o
);

  localparam int c_CW = $clog2(MAX_OUT) + 1;
  localparam int c_PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic [0:0] {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t        r_state;
  logic               r_lock_sel;
  logic               r_pref;
  logic [c_CW-1:0]    r_count;
  logic [c_PW-1:0]    r_wptr;
  logic [c_PW-1:0]    r_rptr;
  logic [MAX_OUT-1:0] r_owner;
  logic               r_spurious;

  logic w_any_req;
  logic w_room;
  logic w_s_req;
  logic w_arb_sel;
  logic w_sel;
  logic w_grant;
  logic w_nonempty;
  logic w_pop;
  logic w_head;

  function automatic logic [c_PW-1:0] f_next(input logic [c_PW-1:0] p);
    return (p == c_PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_any_req  = m0.req | m1.req;
  assign w_room     = (r_count < c_CW'(MAX_OUT));
  assign w_s_req    = w_any_req & w_room & ~rst_i;

  always_comb begin
    w_arb_sel = 1'b0;
    if (m0.req && m1.req) begin
      w_arb_sel = r_pref;
    end else if (m1.req) begin
      w_arb_sel = 1'b1;
    end
  end

  // A pending, ungranted request keeps its master even if preference changes.
  assign w_sel      = (r_state == ST_LOCKED) ? r_lock_sel : w_arb_sel;
  assign w_grant    = w_s_req & s.gnt;
  assign w_nonempty = (r_count != '0);
  assign w_pop      = s.rvalid & w_nonempty & ~rst_i;
  assign w_head     = r_owner[r_rptr];

  assign s.req   = w_s_req;
  assign s.we    = w_sel ? m1.we    : m0.we;
  assign s.be    = w_sel ? m1.be    : m0.be;
  assign s.addr  = w_sel ? m1.addr  : m0.addr;
  assign s.wdata = w_sel ? m1.wdata : m0.wdata;

  assign m0.gnt    = w_grant & ~w_sel;
  assign m1.gnt    = w_grant &  w_sel;
  assign m0.rvalid = w_pop & ~w_head;
  assign m1.rvalid = w_pop &  w_head;
  assign m0.rdata  = (w_pop & ~w_head) ? s.rdata : '0;
  assign m1.rdata  = (w_pop &  w_head) ? s.rdata : '0;
  assign m0.err    = (w_pop & ~w_head) ? s.err   : 1'b0;
  assign m1.err    = (w_pop &  w_head) ? s.err   : 1'b0;

  assign spurious_o = r_spurious;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_OPEN;
      r_lock_sel <= 1'b0;
      r_pref     <= 1'b0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_owner    <= '0;
      r_spurious <= 1'b0;
    end else begin
      if (w_s_req && !s.gnt) begin
        r_state    <= ST_LOCKED;
        r_lock_sel <= w_sel;
      end else begin
        r_state    <= ST_OPEN;
      end

      if (w_grant) begin
        r_pref          <= ~w_sel;
        r_owner[r_wptr] <= w_sel;
        r_wptr          <= f_next(r_wptr);
      end

      if (w_pop) begin
        r_rptr <= f_next(r_rptr);
      end

      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // Responses with nothing outstanding (e.g. issued before a reset) are dropped.
      if (s.rvalid && !w_nonempty) begin
        r_spurious <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_2m.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_bus_arbiter_2m : directed self-checking bench for             |
// | bus_arbiter_2m.  Rev 1.0                                         |
// +------------------------------------------------------------------+
module tb_bus_arbiter_2m;

  logic clk;
  logic rst;
  logic spurious;
  int   n_vec;
  int   n_err;

  bus_arbiter_2m_if #(.AW(32), .DW(32)) m0_if ();
  bus_arbiter_2m_if #(.AW(32), .DW(32)) m1_if ();
  bus_arbiter_2m_if #(.AW(32), .DW(32)) s_if ();

  bus_arbiter_2m #(.AW(32), .DW(32), .MAX_OUT(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if),
    .spurious_o (spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    m0_if.req = 0; m0_if.we = 0; m0_if.be = 4'hF; m0_if.addr = '0; m0_if.wdata = '0;
    m1_if.req = 0; m1_if.we = 0; m1_if.be = 4'hF; m1_if.addr = '0; m1_if.wdata = '0;
    s_if.gnt = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.err = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    m0_if.req = 1; m1_if.req = 1; s_if.gnt = 1;
    tick(); #1;
    n_vec++; if (s_if.req !== 1'b0) begin n_err++; $display("FAIL reset_s_req got=%b exp=0", s_if.req); end
    n_vec++; if ({m1_if.gnt, m0_if.gnt} !== 2'b00) begin n_err++; $display("FAIL reset_gnt got=%b exp=00", {m1_if.gnt, m0_if.gnt}); end
    n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL reset_spurious got=%b exp=0", spurious); end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    m0_if.req = 1; m0_if.addr = 32'h100; s_if.gnt = 1; #1;
    n_vec++; if ({m1_if.gnt, m0_if.gnt} !== 2'b01) begin n_err++; $display("FAIL single_gnt got=%b exp=01", {m1_if.gnt, m0_if.gnt}); end
    n_vec++; if (s_if.addr !== 32'h100) begin n_err++; $display("FAIL single_addr got=%h exp=00000100", s_if.addr); end
    tick();
    m0_if.req = 0; s_if.gnt = 0; s_if.rvalid = 1; s_if.rdata = 32'hA5; #1;
    n_vec++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'hA5) begin n_err++; $display("FAIL single_rsp got=%b/%h exp=1/000000a5", m0_if.rvalid, m0_if.rdata); end
    n_vec++; if (m1_if.rvalid !== 1'b0 || m1_if.rdata !== 32'h0) begin n_err++; $display("FAIL single_m1_quiet got=%b/%h exp=0/00000000", m1_if.rvalid, m1_if.rdata); end
    tick();
    idle();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [4];
    logic [1:0] exp_rv  [5];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    m0_if.req = 1; m0_if.addr = 32'hA0;
    m1_if.req = 1; m1_if.addr = 32'hB0;
    s_if.gnt = 1;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) begin m0_if.req = 0; m1_if.req = 0; s_if.gnt = 0; end
      s_if.rvalid = (c != 0);
      s_if.rdata  = 32'h10 + c;
      s_if.err    = (c == 2);
      #1;
      if (c < 4) begin
        n_vec++; if ({m1_if.gnt, m0_if.gnt} !== exp_gnt[c]) begin n_err++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", c, {m1_if.gnt, m0_if.gnt}, exp_gnt[c]); end
      end
      if (c > 0) begin
        n_vec++; if ({m1_if.rvalid, m0_if.rvalid} !== exp_rv[c]) begin n_err++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", c, {m1_if.rvalid, m0_if.rvalid}, exp_rv[c]); end
      end
      if (c == 2) begin
        n_vec++; if (m1_if.err !== 1'b1 || m1_if.rdata !== 32'h12 || m0_if.err !== 1'b0) begin n_err++; $display("FAIL rr_err got=%b/%h/%b exp=1/00000012/0", m1_if.err, m1_if.rdata, m0_if.err); end
      end
      tick();
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    m0_if.req = 1; m1_if.req = 1; s_if.gnt = 1;
    tick(); tick();
    #1;
    n_vec++; if (s_if.req !== 1'b0 || {m1_if.gnt, m0_if.gnt} !== 2'b00) begin n_err++; $display("FAIL full_blocked got=%b/%b exp=0/00", s_if.req, {m1_if.gnt, m0_if.gnt}); end
    tick();
    s_if.rvalid = 1; #1;
    n_vec++; if (s_if.req !== 1'b0) begin n_err++; $display("FAIL full_no_bypass got=%b exp=0", s_if.req); end
    n_vec++; if (m0_if.rvalid !== 1'b1) begin n_err++; $display("FAIL full_pop_m0 got=%b exp=1", m0_if.rvalid); end
    tick();
    s_if.rvalid = 0; #1;
    n_vec++; if (s_if.req !== 1'b1 || {m1_if.gnt, m0_if.gnt} !== 2'b01) begin n_err++; $display("FAIL full_reenable got=%b/%b exp=1/01", s_if.req, {m1_if.gnt, m0_if.gnt}); end
    tick();
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    m0_if.req = 1; m0_if.addr = 32'h10; s_if.gnt = 1;
    tick();
    m0_if.addr = 32'h20; s_if.gnt = 0; s_if.rvalid = 1; #1;
    n_vec++; if (s_if.req !== 1'b1 || s_if.addr !== 32'h20) begin n_err++; $display("FAIL lock_start got=%b/%h exp=1/00000020", s_if.req, s_if.addr); end
    tick();
    s_if.rvalid = 0; m1_if.req = 1; m1_if.addr = 32'h30;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++; if (s_if.addr !== 32'h20 || {m1_if.gnt, m0_if.gnt} !== 2'b00) begin n_err++; $display("FAIL lock_hold[%0d] got=%h/%b exp=00000020/00", c, s_if.addr, {m1_if.gnt, m0_if.gnt}); end
      tick();
    end
    s_if.gnt = 1; #1;
    n_vec++; if ({m1_if.gnt, m0_if.gnt} !== 2'b01 || s_if.addr !== 32'h20) begin n_err++; $display("FAIL lock_m0_gnt got=%b/%h exp=01/00000020", {m1_if.gnt, m0_if.gnt}, s_if.addr); end
    tick();
    m0_if.req = 0; #1;
    n_vec++; if ({m1_if.gnt, m0_if.gnt} !== 2'b10 || s_if.addr !== 32'h30) begin n_err++; $display("FAIL lock_m1_next got=%b/%h exp=10/00000030", {m1_if.gnt, m0_if.gnt}, s_if.addr); end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    m0_if.req = 1; s_if.gnt = 1;
    tick();
    m0_if.req = 0; m1_if.req = 1; s_if.rvalid = 1; s_if.rdata = 32'h77; #1;
    n_vec++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'h77 || m1_if.gnt !== 1'b1) begin n_err++; $display("FAIL b2b_same_cycle got=%b/%h/%b exp=1/00000077/1", m0_if.rvalid, m0_if.rdata, m1_if.gnt); end
    tick();
    m1_if.req = 0; s_if.gnt = 0; #1;
    n_vec++; if ({m1_if.rvalid, m0_if.rvalid} !== 2'b10) begin n_err++; $display("FAIL b2b_count_kept got=%b exp=10", {m1_if.rvalid, m0_if.rvalid}); end
    tick();
    #1;
    n_vec++; if ({m1_if.rvalid, m0_if.rvalid} !== 2'b00) begin n_err++; $display("FAIL b2b_empty got=%b exp=00", {m1_if.rvalid, m0_if.rvalid}); end
    tick();
    s_if.rvalid = 0; #1;
    n_vec++; if (spurious !== 1'b1) begin n_err++; $display("FAIL b2b_spurious got=%b exp=1", spurious); end
    tick();
    idle();
  endtask

  task automatic test_reset_spurious();
    do_reset();
    m0_if.req = 1; s_if.gnt = 1;
    tick();
    m0_if.req = 0; s_if.gnt = 0; rst = 1; s_if.rvalid = 1; #1;
    n_vec++; if ({m1_if.rvalid, m0_if.rvalid} !== 2'b00) begin n_err++; $display("FAIL rstsp_in_reset got=%b exp=00", {m1_if.rvalid, m0_if.rvalid}); end
    tick();
    rst = 0; #1;
    n_vec++; if ({m1_if.rvalid, m0_if.rvalid} !== 2'b00) begin n_err++; $display("FAIL rstsp_dropped got=%b exp=00", {m1_if.rvalid, m0_if.rvalid}); end
    n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL rstsp_not_yet got=%b exp=0", spurious); end
    tick();
    s_if.rvalid = 0; #1;
    n_vec++; if (spurious !== 1'b1) begin n_err++; $display("FAIL rstsp_set got=%b exp=1", spurious); end
    tick(); tick(); #1;
    n_vec++; if (spurious !== 1'b1) begin n_err++; $display("FAIL rstsp_sticky got=%b exp=1", spurious); end
    do_reset(); #1;
    n_vec++; if (spurious !== 1'b0) begin n_err++; $display("FAIL rstsp_cleared got=%b exp=0", spurious); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_single_read();
    test_round_robin();
    test_full();
    test_lock();
    test_back_to_back();
    test_reset_spurious();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
